// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__bufz_bus_arb
// Brief    : Round-robin arbiter / break-before-make enable sequencer for a
//            shared bufz tristate bus, with tenure hold timeout.
//            Optional macro GF180MCU_BUFZ_ARB_PARK_EN parks the bus on the
//            last owner while idle.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__bufz_bus_arb #(
    parameter int N        = 4,
    parameter int DEAD_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] GNT,
    output logic [N-1:0] EN,
    output logic         BUSY
);

    localparam int c_IDX_W      = $clog2(N);
    localparam int c_HOLD_SAT_I = (MAX_HOLD > 0) ? MAX_HOLD : 1;
    localparam int c_HOLD_W     = $clog2(c_HOLD_SAT_I + 1);
    localparam int c_DEAD_W     = $clog2(DEAD_CYC + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT  = c_HOLD_W'(c_HOLD_SAT_I);
    localparam logic [c_DEAD_W-1:0] c_DEAD_LAST = c_DEAD_W'(DEAD_CYC);
    localparam logic [c_DEAD_W-1:0] c_DEAD_ONE  = c_DEAD_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(N - 1);
    localparam logic [c_IDX_W:0]    c_N_EXT     = (c_IDX_W + 1)'(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRIVE = 2'b01,
        S_DEAD  = 2'b10
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [c_DEAD_W-1:0]  r_dead;

    state_t               w_state_nx;
    logic [c_IDX_W-1:0]   w_rr_nx;
    logic [c_IDX_W-1:0]   w_owner_nx;
    logic [c_HOLD_W-1:0]  w_hold_nx;
    logic [c_DEAD_W-1:0]  w_dead_nx;
    logic [N-1:0]         w_gnt_nx;
    logic [N-1:0]         w_en_nx;
    logic                 w_busy_nx;

`ifdef GF180MCU_BUFZ_ARB_PARK_EN
    logic                 r_parked;
    logic                 w_parked_nx;
`endif

    logic                 w_any;
    logic                 w_found;
    logic [c_IDX_W:0]     w_arb_sum;
    logic [c_IDX_W-1:0]   w_win;
    logic [N-1:0]         w_others;
    logic                 w_timeout;
    logic                 w_release;

    function automatic logic [N-1:0] f_onehot(input logic [c_IDX_W-1:0] idx);
        f_onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // First asserted request at or after the RR pointer, wrapping N-1 -> 0.
    always_comb begin
        w_any     = |REQ;
        w_found   = 1'b0;
        w_win     = '0;
        w_arb_sum = '0;
        for (int k = 0; k < N; k++) begin
            w_arb_sum = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
            if (w_arb_sum >= c_N_EXT) begin
                w_arb_sum = w_arb_sum - c_N_EXT;
            end
            if (!w_found && REQ[w_arb_sum[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_arb_sum[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_others  = REQ & ~f_onehot(r_owner);
        w_timeout = (MAX_HOLD != 0) && (r_hold >= c_HOLD_SAT) && (|w_others);
        w_release = !REQ[r_owner] || w_timeout;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_rr_nx     = r_rr_ptr;
        w_owner_nx  = r_owner;
        w_hold_nx   = r_hold;
        w_dead_nx   = r_dead;
`ifdef GF180MCU_BUFZ_ARB_PARK_EN
        w_parked_nx = r_parked;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
`ifdef GF180MCU_BUFZ_ARB_PARK_EN
                    // A new owner must wait for the parked driver to turn off.
                    if (r_parked && (w_win != r_owner)) begin
                        w_state_nx  = S_DEAD;
                        w_dead_nx   = c_DEAD_ONE;
                        w_parked_nx = 1'b0;
                    end else begin
                        w_state_nx  = S_DRIVE;
                        w_owner_nx  = w_win;
                        w_hold_nx   = c_HOLD_ONE;
                        w_parked_nx = 1'b0;
                    end
`else
                    w_state_nx = S_DRIVE;
                    w_owner_nx = w_win;
                    w_hold_nx  = c_HOLD_ONE;
`endif
                end
            end
            S_DRIVE: begin
                if (w_release) begin
                    w_rr_nx   = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
                    w_hold_nx = '0;
`ifdef GF180MCU_BUFZ_ARB_PARK_EN
                    if (!w_any) begin
                        w_state_nx  = S_IDLE;
                        w_parked_nx = 1'b1;
                    end else begin
                        w_state_nx = S_DEAD;
                        w_dead_nx  = c_DEAD_ONE;
                    end
`else
                    w_state_nx = S_DEAD;
                    w_dead_nx  = c_DEAD_ONE;
`endif
                end else if (r_hold != c_HOLD_SAT) begin
                    w_hold_nx = r_hold + 1'b1;
                end
            end
            S_DEAD: begin
                // REQ is only looked at on the edge that ends the last dead cycle.
                if (r_dead >= c_DEAD_LAST) begin
                    w_dead_nx = '0;
                    if (w_any) begin
                        w_state_nx = S_DRIVE;
                        w_owner_nx = w_win;
                        w_hold_nx  = c_HOLD_ONE;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_dead_nx = r_dead + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_busy_nx = (w_state_nx == S_DRIVE);
        w_gnt_nx  = w_busy_nx ? f_onehot(w_owner_nx) : '0;
        w_en_nx   = w_gnt_nx;
`ifdef GF180MCU_BUFZ_ARB_PARK_EN
        if ((w_state_nx == S_IDLE) && w_parked_nx) begin
            w_en_nx = f_onehot(w_owner_nx);
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_hold   <= '0;
            r_dead   <= '0;
            GNT      <= '0;
            EN       <= '0;
            BUSY     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_rr_ptr <= w_rr_nx;
            r_owner  <= w_owner_nx;
            r_hold   <= w_hold_nx;
            r_dead   <= w_dead_nx;
            GNT      <= w_gnt_nx;
            EN       <= w_en_nx;
            BUSY     <= w_busy_nx;
        end
    end

`ifdef GF180MCU_BUFZ_ARB_PARK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_parked <= 1'b0;
        end else begin
            r_parked <= w_parked_nx;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufz_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu7t5v0__bufz_bus_arb
// Brief    : Scoreboard bench for the bufz bus arbiter against a behavioural
//            tenure/gap model (honours GF180MCU_BUFZ_ARB_PARK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu7t5v0__bufz_bus_arb;

    localparam int N        = 4;
    localparam int DEAD_CYC = 2;
    localparam int MAX_HOLD = 4;

    logic         CLK;
    logic         RST;
    logic [N-1:0] REQ;
    logic [N-1:0] GNT;
    logic [N-1:0] EN;
    logic         BUSY;

    gf180mcu_fd_sc_mcu7t5v0__bufz_bus_arb #(
        .N        (N),
        .DEAD_CYC (DEAD_CYC),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .GNT  (GNT),
        .EN   (EN),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [2*N:0] q[$];

    // Model: who drives (-1 none), how long they have held, dead cycles left,
    // round-robin start point, and the parked driver (-1 none).
    int m_owner  = -1;
    int m_tenure = 0;
    int m_gap    = 0;
    int m_ptr    = 0;
    int m_parked = -1;

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_gap    = 0;
        m_ptr    = 0;
        m_parked = -1;
    endtask

    function automatic int arb(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r);
        int w;
        logic [N-1:0] oth;
        if (m_owner >= 0) begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (!r[m_owner] || (MAX_HOLD > 0 && m_tenure >= MAX_HOLD && oth != '0)) begin
                m_ptr = (m_owner + 1) % N;
`ifdef GF180MCU_BUFZ_ARB_PARK_EN
                if (r == '0) begin
                    m_parked = m_owner;
                    m_owner  = -1;
                end else begin
                    m_owner = -1;
                    m_gap   = DEAD_CYC;
                end
`else
                m_owner = -1;
                m_gap   = DEAD_CYC;
`endif
            end else begin
                m_tenure++;
            end
        end else if (m_gap > 0) begin
            if (m_gap == 1) begin
                m_gap = 0;
                w = arb(r);
                if (w >= 0) begin
                    m_owner  = w;
                    m_tenure = 1;
                end
            end else begin
                m_gap--;
            end
        end else begin
            w = arb(r);
            if (w >= 0) begin
                if (m_parked >= 0 && w != m_parked) begin
                    m_parked = -1;
                    m_gap    = DEAD_CYC;
                end else begin
                    m_owner  = w;
                    m_tenure = 1;
                    m_parked = -1;
                end
            end
        end
    endtask

    function automatic logic [2*N:0] model_outputs();
        logic [N-1:0] g;
        logic [N-1:0] e;
        g = '0;
        e = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        e = g;
        if (m_parked >= 0) e[m_parked] = 1'b1;
        return {g, e, (m_owner >= 0)};
    endfunction

    // REQ changes mid-cycle; the expected post-edge outputs are queued.
    task automatic drive(input logic [N-1:0] r);
        @(negedge CLK);
        REQ = r;
        model_step(r);
        q.push_back(model_outputs());
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (EN !== '0 || GNT !== '0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s: got gnt=%b en=%b busy=%b, expected all zero", name, GNT, EN, BUSY);
        end
    endtask

    task automatic async_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_zero("async_reset_mid_cycle");
        REQ = '0;
        @(posedge CLK);
        #2 RST = 1'b0;
        model_reset();
    endtask

    // Monitor: scoreboard compare plus contention / dead-gap properties.
    int cyc        = 0;
    int last_owner = -1;
    int zero_run   = 1000;

    initial begin
        logic [2*N:0] exp_v;
        int cur;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (q.size() > 0) begin
                exp_v = q.pop_front();
                checks++;
                if ({GNT, EN, BUSY} !== exp_v) begin
                    failures++;
                    $display("FAIL scoreboard cycle %0d: got gnt=%b en=%b busy=%b, expected gnt=%b en=%b busy=%b",
                             cyc, GNT, EN, BUSY, exp_v[2*N:N+1], exp_v[N:1], exp_v[0]);
                end
            end
            if (RST) begin
                last_owner = -1;
                zero_run   = 1000;
            end else begin
                checks++;
                if (!$onehot0(EN) || !$onehot0(GNT)) begin
                    failures++;
                    $display("FAIL onehot0 cycle %0d: got gnt=%b en=%b, expected at most one bit each",
                             cyc, GNT, EN);
                end
                if (EN == '0) begin
                    zero_run++;
                end else begin
                    cur = 0;
                    for (int i = 0; i < N; i++) if (EN[i]) cur = i;
                    if (last_owner >= 0 && cur != last_owner) begin
                        checks++;
                        if (zero_run < DEAD_CYC) begin
                            failures++;
                            $display("FAIL dead_gap cycle %0d: got %0d off cycles before owner %0d, expected >= %0d",
                                     cyc, zero_run, cur, DEAD_CYC);
                        end
                    end
                    last_owner = cur;
                    zero_run   = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        REQ = '0;
        RST = 1'b0;
        #1 RST = 1'b1;
        #11 check_zero("reset_state");
        @(posedge CLK);
        #2 RST = 1'b0;
        model_reset();

        repeat (4) drive(4'b0001);
        repeat (2) drive(4'b0000);

        repeat (40) drive(4'b1111);
        repeat (3)  drive(4'b0000);

        repeat (3) drive(4'b0001);
        drive(4'b0101);
        repeat (6) drive(4'b0100);
        repeat (3) drive(4'b0000);

        repeat (40) drive(4'b0010);
        async_reset();
        repeat (3) drive(4'b0001);
        repeat (3) drive(4'b0000);

        repeat (3) drive(4'b1000);
        repeat (3) drive(4'b0000);
        repeat (3) drive(4'b1000);
        repeat (2) drive(4'b0000);
        repeat (5) drive(4'b0001);
        repeat (3) drive(4'b0000);

        r = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            drive(r);
            if (c == 5000) async_reset();
        end
        repeat (4) drive(4'b0000);

        @(posedge CLK);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
